// File: rtl/revaluate_datapath_pkg.sv
// rtl/revaluate_datapath_pkg.sv - shared constants and width helper for the revaluate datapath
package revaluate_datapath_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Index width for an N-entry dataset, never narrower than one bit.
    function automatic int len_addr(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/revaluate_datapath_sat_adder.sv
// rtl/revaluate_datapath_sat_adder.sv - unsigned accumulator plus sample, clamped at all-ones
module sat_adder #(
    parameter int ACC_W  = 12,
    parameter int DATA_W = 8
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [DATA_W-1:0] i_sample,
    output logic [ACC_W-1:0]  o_sum
);

    logic [ACC_W:0] w_full;

    assign w_full = {1'b0, i_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, i_sample};
    assign o_sum  = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule

// File: rtl/revaluate_datapath.sv
// rtl/revaluate_datapath.sv - walks the dataset ROM, writes saturated running sums to the result RAM
module revaluate_datapath
    import revaluate_datapath_pkg::*;
#(
    parameter int N      = 16,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12,
    parameter int THRESH = 128,
    parameter int ADDR_W = len_addr(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dataset_reset,
    input  logic              write,
    input  logic              count,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ACC_W-1:0]  wr_data,
    output logic              datapath_done,
    output logic [ACC_W-1:0]  sum,
    output logic [ADDR_W:0]   hit_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    logic [ADDR_W-1:0] r_idx;
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_idx;
    logic [ACC_W-1:0]  r_sum;
    logic [ADDR_W:0]   r_hit_cnt;
    logic              r_last_issued;

    logic [ACC_W-1:0]  w_nxt;
    logic              w_hit;
    logic              w_commit;

    sat_adder #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_sat_adder (
        .i_acc    (r_sum),
        .i_sample (rom_rdata),
        .o_sum    (w_nxt)
    );

    assign w_hit    = ({{(32 - DATA_W){1'b0}}, rom_rdata} > 32'(THRESH));
    assign w_commit = r_s1_valid & write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_s1_valid    <= DISABLE;
            r_s1_idx      <= '0;
            r_sum         <= '0;
            r_hit_cnt     <= '0;
            r_last_issued <= DISABLE;
        end else if (dataset_reset) begin
            r_idx         <= '0;
            r_s1_valid    <= DISABLE;
            r_s1_idx      <= '0;
            r_sum         <= '0;
            r_hit_cnt     <= '0;
            r_last_issued <= DISABLE;
        end else begin
            // Index parks on the last sample so extra count cycles issue nothing.
            if (count && !r_last_issued) begin
                r_s1_valid <= ENABLE;
                r_s1_idx   <= r_idx;
                if (r_idx == LAST_IDX) begin
                    r_last_issued <= ENABLE;
                end else begin
                    r_idx <= r_idx + {{(ADDR_W - 1){1'b0}}, 1'b1};
                end
            end else begin
                r_s1_valid <= DISABLE;
            end
            if (w_commit) begin
                r_sum <= w_nxt;
                if (w_hit) begin
                    r_hit_cnt <= r_hit_cnt + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
        end
    end

    assign rom_addr      = r_idx;
    assign wr_en         = w_commit;
    assign wr_addr       = r_s1_idx;
    assign wr_data       = w_nxt;
    assign datapath_done = w_commit & (r_s1_idx == LAST_IDX);
    assign sum           = r_sum;
    assign hit_cnt       = r_hit_cnt;

endmodule

// File: tb/tb_revaluate_datapath.sv
// tb/tb_revaluate_datapath.sv - directed vector bench for revaluate_datapath
module tb_revaluate_datapath;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dsr = 1'b0;
    logic cnt = 1'b0;
    logic wr  = 1'b0;

    always #5 clk = ~clk;

    // DUT A: N=4, ACC_W=12
    logic [1:0]  a_raddr, a_waddr;
    logic [7:0]  a_rdata;
    logic        a_wen, a_done;
    logic [11:0] a_wdata, a_sum;
    logic [2:0]  a_hit;
    logic [7:0]  rom_a [4];

    // DUT B: N=4, ACC_W=8
    logic [1:0]  b_raddr, b_waddr;
    logic [7:0]  b_rdata;
    logic        b_wen, b_done;
    logic [7:0]  b_wdata, b_sum;
    logic [2:0]  b_hit;
    logic [7:0]  rom_b [4];

    // DUT C: N=1
    logic        c_raddr, c_waddr;
    logic [7:0]  c_rdata;
    logic        c_wen, c_done;
    logic [11:0] c_wdata, c_sum;
    logic [1:0]  c_hit;
    logic [7:0]  rom_c [2];

    always @(posedge clk) begin
        a_rdata <= rom_a[a_raddr];
        b_rdata <= rom_b[b_raddr];
        c_rdata <= rom_c[c_raddr];
    end

    revaluate_datapath #(.N(4), .DATA_W(8), .ACC_W(12), .THRESH(128)) u_a (
        .clk(clk), .rst(rst), .dataset_reset(dsr), .write(wr), .count(cnt),
        .rom_addr(a_raddr), .rom_rdata(a_rdata), .wr_en(a_wen), .wr_addr(a_waddr),
        .wr_data(a_wdata), .datapath_done(a_done), .sum(a_sum), .hit_cnt(a_hit)
    );

    revaluate_datapath #(.N(4), .DATA_W(8), .ACC_W(8), .THRESH(128)) u_b (
        .clk(clk), .rst(rst), .dataset_reset(dsr), .write(wr), .count(cnt),
        .rom_addr(b_raddr), .rom_rdata(b_rdata), .wr_en(b_wen), .wr_addr(b_waddr),
        .wr_data(b_wdata), .datapath_done(b_done), .sum(b_sum), .hit_cnt(b_hit)
    );

    revaluate_datapath #(.N(1), .DATA_W(8), .ACC_W(12), .THRESH(128)) u_c (
        .clk(clk), .rst(rst), .dataset_reset(dsr), .write(wr), .count(cnt),
        .rom_addr(c_raddr), .rom_rdata(c_rdata), .wr_en(c_wen), .wr_addr(c_waddr),
        .wr_data(c_wdata), .datapath_done(c_done), .sum(c_sum), .hit_cnt(c_hit)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic d, input logic c, input logic w);
        dsr = d;
        cnt = c;
        wr  = w;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic d, c, w;
        logic en;
        int   addr;
        int   data;
        logic done;
        int   sum;
        int   raddr;
        int   hit;
    } vec_t;

    vec_t tbl [9];

    // Scenario 1 then 4 on DUT A with ROM {10,20,30,40}.
    task automatic run_table(input string tag);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].d, tbl[i].c, tbl[i].w);
            chk($sformatf("%s[%0d] wr_en", tag, i), 32'(a_wen), 32'(tbl[i].en));
            if (tbl[i].en) begin
                chk($sformatf("%s[%0d] wr_addr", tag, i), 32'(a_waddr), tbl[i].addr);
                chk($sformatf("%s[%0d] wr_data", tag, i), 32'(a_wdata), tbl[i].data);
            end
            chk($sformatf("%s[%0d] done", tag, i), 32'(a_done), 32'(tbl[i].done));
            chk($sformatf("%s[%0d] sum", tag, i), 32'(a_sum), tbl[i].sum);
            chk($sformatf("%s[%0d] rom_addr", tag, i), 32'(a_raddr), tbl[i].raddr);
            chk($sformatf("%s[%0d] hit_cnt", tag, i), 32'(a_hit), tbl[i].hit);
        end
    endtask

    task automatic load_roms(input logic [7:0] v0, input logic [7:0] v1,
                             input logic [7:0] v2, input logic [7:0] v3);
        rom_a[0] = v0; rom_a[1] = v1; rom_a[2] = v2; rom_a[3] = v3;
        rom_b[0] = v0; rom_b[1] = v1; rom_b[2] = v2; rom_b[3] = v3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_a [4];
        int exp_b [4];

        //           d  c  w  en addr data done sum raddr hit
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   0, 1'b0,   0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 0,  10, 1'b0,   0, 1, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1,  30, 1'b0,  10, 2, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 2,  60, 1'b0,  30, 3, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 3, 100, 1'b1,  60, 3, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 0,   0, 1'b0, 100, 3, 0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 0,   0, 1'b0, 100, 3, 0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 0,   0, 1'b0, 100, 3, 0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 0,   0, 1'b0, 100, 3, 0};

        load_roms(8'd10, 8'd20, 8'd30, 8'd40);
        rom_c[0] = 8'd7;
        rom_c[1] = 8'd0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("reset rom_addr", 32'(a_raddr), 0);
        chk("reset sum", 32'(a_sum), 0);
        chk("reset hit_cnt", 32'(a_hit), 0);
        chk("reset wr_en", 32'(a_wen), 0);
        chk("reset done", 32'(a_done), 0);
        chk("reset wr_addr", 32'(a_waddr), 0);
        rst = 1'b0;

        run_table("run1");

        // Saturation and threshold counting
        load_roms(8'd200, 8'd150, 8'd5, 8'd129);
        exp_a = '{200, 350, 355, 484};
        exp_b = '{200, 255, 255, 255};
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk($sformatf("sat a wr_data[%0d]", i), 32'(a_wdata), exp_a[i]);
            chk($sformatf("sat b wr_data[%0d]", i), 32'(b_wdata), exp_b[i]);
            chk($sformatf("sat b wr_addr[%0d]", i), 32'(b_waddr), i);
        end
        step(1'b0, 1'b1, 1'b1);
        chk("sat a sum", 32'(a_sum), 484);
        chk("sat a hit_cnt", 32'(a_hit), 3);
        chk("sat b sum", 32'(b_sum), 255);
        chk("sat b hit_cnt", 32'(b_hit), 3);

        // Stall after index 1 issued
        load_roms(8'd10, 8'd20, 8'd30, 8'd40);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("stall w0 addr", 32'(a_waddr), 0);
        step(1'b0, 1'b1, 1'b1);
        chk("stall w1 en", 32'(a_wen), 1);
        chk("stall w1 data", 32'(a_wdata), 30);
        step(1'b0, 1'b0, 1'b1);
        chk("stall gap0 wr_en", 32'(a_wen), 0);
        chk("stall gap0 sum", 32'(a_sum), 30);
        step(1'b0, 1'b0, 1'b1);
        chk("stall gap1 wr_en", 32'(a_wen), 0);
        chk("stall gap1 rom_addr", 32'(a_raddr), 2);
        step(1'b0, 1'b1, 1'b1);
        chk("stall w2 en", 32'(a_wen), 1);
        chk("stall w2 addr", 32'(a_waddr), 2);
        chk("stall w2 data", 32'(a_wdata), 60);
        step(1'b0, 1'b1, 1'b1);
        chk("stall w3 addr", 32'(a_waddr), 3);
        chk("stall w3 data", 32'(a_wdata), 100);
        chk("stall w3 done", 32'(a_done), 1);
        step(1'b0, 1'b1, 1'b1);
        chk("stall final sum", 32'(a_sum), 100);
        chk("stall final wr_en", 32'(a_wen), 0);

        // Asynchronous reset mid-run, then rerun
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("midrst pre wr_addr", 32'(a_waddr), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst rom_addr", 32'(a_raddr), 0);
        chk("midrst sum", 32'(a_sum), 0);
        chk("midrst hit_cnt", 32'(a_hit), 0);
        chk("midrst wr_en", 32'(a_wen), 0);
        chk("midrst done", 32'(a_done), 0);
        chk("midrst wr_addr", 32'(a_waddr), 0);
        step(1'b0, 1'b1, 1'b1);
        chk("midrst held wr_en", 32'(a_wen), 0);
        chk("midrst held rom_addr", 32'(a_raddr), 0);
        cnt = 1'b0;
        rst = 1'b0;
        run_table("rerun");

        // Clear wins over count; N=1 run
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("clr rom_addr", 32'(a_raddr), 0);
        chk("clr wr_en", 32'(a_wen), 0);
        chk("clr sum", 32'(a_sum), 0);
        step(1'b0, 1'b1, 1'b1);
        chk("n1 wr_en", 32'(c_wen), 1);
        chk("n1 wr_addr", 32'(c_waddr), 0);
        chk("n1 wr_data", 32'(c_wdata), 7);
        chk("n1 done", 32'(c_done), 1);
        step(1'b0, 1'b1, 1'b1);
        chk("n1 sum", 32'(c_sum), 7);
        chk("n1 post wr_en", 32'(c_wen), 0);
        chk("n1 post done", 32'(c_done), 0);
        chk("n1 hit_cnt", 32'(c_hit), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
